// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the sequence FSM blocks: state encodings and
// default parameter values.
package seq_fsm_pkg;

  // FSM state encodings (2'b11 is unused and recovers to IDLE)
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_BAD  = 2'b11;

  // Default geometry: 8-bit pattern, 4-bit length and repeat fields
  localparam int DEF_WIDTH = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_REP_W = 4;

endpackage

// File: rtl/seq_gen_if.sv
// Load / serial-output bus of the sequence generator.
// The master side loads patterns and paces bits; the slave is seq_gen.
interface seq_gen_if #(
  parameter int WIDTH = seq_fsm_pkg::DEF_WIDTH,
  parameter int LEN_W = seq_fsm_pkg::DEF_LEN_W,
  parameter int REP_W = seq_fsm_pkg::DEF_REP_W
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] rep;
  logic             tx_en;
  logic             dout;
  logic             dout_valid;
  logic             done;
  logic [1:0]       state;

  modport master (
    output load_valid, pattern, len, rep, tx_en,
    input  load_ready, dout, dout_valid, done, state
  );

  modport slave (
    input  load_valid, pattern, len, rep, tx_en,
    output load_ready, dout, dout_valid, done, state
  );
endinterface

// File: rtl/seq_bitcnt.sv
// Bit-index and repeat down-counter for seq_gen.
// Index walks len-1 .. 0, reloads from the captured start value while
// repeats remain, and flags the final bit of the final repetition.
module seq_bitcnt
  import seq_fsm_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] idx_init,
  input  logic [REP_W-1:0] rep_init,
  input  logic             dec,
  output logic [LEN_W-1:0] idx,
  output logic             last
);

  localparam logic [LEN_W-1:0] IDX_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  logic [LEN_W-1:0] idx_r;
  logic [LEN_W-1:0] reload_r;
  logic [REP_W-1:0] rep_r;

  // Load on accept, otherwise count down one bit per enabled emission
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_r    <= {LEN_W{1'b0}};
      reload_r <= {LEN_W{1'b0}};
      rep_r    <= {REP_W{1'b0}};
    end else if (load) begin
      idx_r    <= idx_init;
      reload_r <= idx_init;
      rep_r    <= rep_init;
    end else if (dec) begin
      if (idx_r != {LEN_W{1'b0}}) begin
        idx_r <= idx_r - IDX_ONE;
      end else if (rep_r != {REP_W{1'b0}}) begin
        // Wrap straight into the next repetition, no idle bit between
        idx_r <= reload_r;
        rep_r <= rep_r - REP_ONE;
      end else begin
        idx_r <= idx_r;
        rep_r <= rep_r;
      end
    end else begin
      idx_r <= idx_r;
      rep_r <= rep_r;
    end
  end

  assign idx  = idx_r;
  assign last = (idx_r == {LEN_W{1'b0}}) && (rep_r == {REP_W{1'b0}});

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: accepts a pattern/length/repeat request and
// shifts it out MSB-first (from bit len-1), one bit per tx_en tick,
// repeating it rep+1 times, then pulses done for one cycle.
module seq_gen
  import seq_fsm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W
) (
  input logic       clk,
  input logic       rst,
  seq_gen_if.slave  bus
);

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] IDX_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] BIT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic             dout_r;
  logic             dout_valid_r;
  logic             done_r;
  logic [WIDTH-1:0] pattern_r;

  logic [LEN_W-1:0] len_clamp_s;
  logic [LEN_W-1:0] idx_init_s;
  logic [LEN_W-1:0] idx_s;
  logic             last_s;
  logic             load_s;
  logic             dec_s;
  logic             cur_bit_s;

  // Clamp requested length to the pattern width and derive the start index
  always_comb begin
    len_clamp_s = bus.len;
    if (bus.len > WIDTH_L) begin
      len_clamp_s = WIDTH_L;
    end else begin
      len_clamp_s = bus.len;
    end
    // Wraps for len==0, but that request never enters SEND
    idx_init_s = len_clamp_s - IDX_ONE;
  end

  assign load_s    = (state_r == ST_IDLE) && bus.load_valid;
  assign dec_s     = (state_r == ST_SEND) && bus.tx_en;
  assign cur_bit_s = |(pattern_r & (BIT_ONE << idx_s));

  seq_bitcnt #(
    .LEN_W (LEN_W),
    .REP_W (REP_W)
  ) u_bitcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .idx_init (idx_init_s),
    .rep_init (bus.rep),
    .dec      (dec_s),
    .idx      (idx_s),
    .last     (last_s)
  );

  // Control FSM and registered serial outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      done_r       <= 1'b0;
      pattern_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          dout_valid_r <= 1'b0;
          if (load_s) begin
            pattern_r <= bus.pattern;
            if (len_clamp_s != {LEN_W{1'b0}}) begin
              state_r <= ST_SEND;
              done_r  <= 1'b0;
            end else begin
              // Empty pattern: complete immediately without any bit
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (bus.tx_en) begin
            dout_r       <= cur_bit_s;
            dout_valid_r <= 1'b1;
            if (last_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_SEND;
              done_r  <= 1'b0;
            end
          end else begin
            // No tick: keep the last bit on dout, but it is not new
            dout_valid_r <= 1'b0;
            done_r       <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          dout_r       <= 1'b0;
          dout_valid_r <= 1'b0;
          done_r       <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          dout_r       <= 1'b0;
          dout_valid_r <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = (state_r == ST_IDLE);
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.done       = done_r;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed scenarios plus a randomized
// run, all compared against a queue-based model of the bit stream.
module tb_seq_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seq_gen_if #(.WIDTH(8), .LEN_W(4), .REP_W(4)) bus ();

  seq_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle / 1 sending / 2 done, and the bits still owed
  int m_phase = 0;
  bit m_dout  = 1'b0;
  bit m_valid = 1'b0;
  bit m_done  = 1'b0;
  bit q[$];

  wire [5:0] obs = {bus.state, bus.load_ready, bus.dout_valid, bus.dout, bus.done};

  function automatic logic [5:0] exp_vec();
    return {2'(m_phase), (m_phase == 0), m_valid, m_dout, m_done};
  endfunction

  // One clock edge; the model consumes the inputs present at that edge
  task automatic tick();
    bit          lv;
    bit          tx;
    bit          r;
    logic [7:0]  pat;
    int          ln;
    int          rp;
    int          n;
    lv  = bus.load_valid;
    tx  = bus.tx_en;
    r   = rst;
    pat = bus.pattern;
    ln  = int'(bus.len);
    rp  = int'(bus.rep);
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_phase = 0; m_dout = 1'b0; m_valid = 1'b0; m_done = 1'b0;
    end else if (m_phase == 0) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (lv) begin
        n = (ln > 8) ? 8 : ln;
        for (int k = 0; k <= rp; k++)
          for (int i = n - 1; i >= 0; i--)
            q.push_back(pat[i]);
        if (q.size() == 0) begin
          m_phase = 2; m_done = 1'b1;
        end else begin
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (tx) begin
        m_dout  = q.pop_front();
        m_valid = 1'b1;
        if (q.size() == 0) begin
          m_phase = 2; m_done = 1'b1;
        end
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_phase = 0; m_valid = 1'b0; m_done = 1'b0; m_dout = 1'b0;
    end
    #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    bus.pattern    = p;
    bus.len        = l;
    bus.rep        = r;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.load_valid = 1'b0; bus.tx_en = 1'b0;
    bus.pattern = 8'h00; bus.len = 4'd0; bus.rep = 4'd0;
    tick(); tick();
    checks++;
    if (obs !== 6'b00_1_0_0_0) begin
      errors++; $display("FAIL reset_state got %b want %b", obs, 6'b00_1_0_0_0);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_release got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_repeat();
    int vcnt = 0; int ones = 0; int done_at = -1;
    bus.tx_en = 1'b1;
    load(8'h07, 4'd3, 4'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL repeat cyc %0d got %b want %b", c, obs, exp_vec());
      end
      if (bus.dout_valid === 1'b1) begin vcnt++; if (bus.dout === 1'b1) ones++; end
      if (bus.done === 1'b1) done_at = vcnt;
    end
    checks++;
    if (vcnt != 6 || ones != 6 || done_at != 6 || bus.state !== 2'b00) begin
      errors++; $display("FAIL repeat_totals valid %0d ones %0d done_at %0d want 6 6 6", vcnt, ones, done_at);
    end
  endtask

  task automatic test_gated();
    logic [7:0] got = 8'h00; int vcnt = 0; logic prev_dout;
    bus.tx_en = 1'b0;
    load(8'hA5, 4'd8, 4'd0);
    prev_dout = bus.dout;
    for (int c = 0; c < 20; c++) begin
      bus.tx_en = (c % 2 == 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL gated cyc %0d got %b want %b", c, obs, exp_vec());
      end
      if (bus.dout_valid === 1'b1) begin got = {got[6:0], bus.dout}; vcnt++; end
      else if (m_phase == 1 && bus.dout !== prev_dout) begin
        errors++; $display("FAIL gated_hold cyc %0d got %b want %b", c, bus.dout, prev_dout);
      end
      prev_dout = bus.dout;
    end
    checks++;
    if (got !== 8'hA5 || vcnt != 8) begin
      errors++; $display("FAIL gated_bits got %h/%0d want a5/8", got, vcnt);
    end
  endtask

  task automatic test_zero_len();
    bus.tx_en = 1'b1;
    load(8'hFF, 4'd0, 4'd3);
    checks++;
    if (obs !== 6'b10_0_0_0_1 || obs !== exp_vec()) begin
      errors++; $display("FAIL zero_len_done got %b want %b", obs, 6'b10_0_0_0_1);
    end
    tick();
    checks++;
    if (obs !== 6'b00_1_0_0_0) begin
      errors++; $display("FAIL zero_len_idle got %b want %b", obs, 6'b00_1_0_0_0);
    end
  endtask

  task automatic test_clamp();
    int vcnt = 0; int ones = 0; int dcnt = 0;
    bus.tx_en = 1'b1;
    load(8'hFF, 4'd12, 4'd0);
    for (int c = 0; c < 14; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL clamp cyc %0d got %b want %b", c, obs, exp_vec());
      end
      if (bus.dout_valid === 1'b1) begin vcnt++; if (bus.dout === 1'b1) ones++; end
      if (bus.done === 1'b1) dcnt++;
    end
    checks++;
    if (vcnt != 8 || ones != 8 || dcnt != 1) begin
      errors++; $display("FAIL clamp_totals valid %0d ones %0d done %0d want 8 8 1", vcnt, ones, dcnt);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt = 0; int vcnt = 0;
    bus.tx_en = 1'b1;
    load(8'($urandom), 4'd5, 4'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 6'b00_1_0_0_0 || obs !== exp_vec()) begin
      errors++; $display("FAIL reset_mid_abort got %b want %b", obs, 6'b00_1_0_0_0);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.done === 1'b1) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++; $display("FAIL reset_mid_no_done got %0d want 0", dcnt);
    end
    load(8'h02, 4'd2, 4'd0);
    checks++;
    if (obs !== exp_vec() || bus.state !== 2'b01) begin
      errors++; $display("FAIL reset_mid_reload got %b want %b", obs, exp_vec());
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.dout_valid === 1'b1) vcnt++;
      if (bus.done === 1'b1) dcnt++;
    end
    checks++;
    if (vcnt != 2 || dcnt != 1) begin
      errors++; $display("FAIL reset_mid_after valid %0d done %0d want 2 1", vcnt, dcnt);
    end
  endtask

  task automatic test_back_to_back();
    int last_done = -100; int sends = 0; logic [1:0] prev_state;
    bus.tx_en = 1'b1;
    bus.pattern = 8'($urandom); bus.len = 4'd2; bus.rep = 4'd0;
    bus.load_valid = 1'b1;
    prev_state = bus.state;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL b2b cyc %0d got %b want %b", c, obs, exp_vec());
      end
      if (bus.state === 2'b01 && prev_state !== 2'b01) begin
        sends++;
        if (last_done >= 0 && c - last_done != 2) begin
          checks++; errors++;
          $display("FAIL b2b_gap got %0d want 2", c - last_done);
        end
      end
      if (bus.done === 1'b1) last_done = c;
      prev_state = bus.state;
    end
    bus.load_valid = 1'b0;
    checks++;
    if (sends != 5) begin
      errors++; $display("FAIL b2b_count got %0d want 5", sends);
    end
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.load_valid = ($urandom_range(99) < 40);
      bus.tx_en      = ($urandom_range(99) < 70);
      bus.pattern    = 8'($urandom);
      bus.len        = 4'($urandom_range(15));
      bus.rep        = 4'($urandom_range(3));
      rst            = ($urandom_range(99) >= 2);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %b want %b", c, obs, exp_vec());
      end
    end
    rst = 1'b1;
    bus.load_valid = 1'b0;
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_repeat();
    test_gated();
    test_zero_len();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, maximum pattern length in bits.
REQ-002 SHALL provide parameter LEN_W, default 4, width of length field; must represent WIDTH.
REQ-003 SHALL provide parameter REP_W, default 4, width of repeat field.
REQ-004 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL provide port load_valid  input  1  pattern load request.
REQ-007 SHALL provide port load_ready  output  1  block can accept a load.
REQ-008 SHALL provide port pattern  input  WIDTH  bits to transmit, MSB-first from bit len-1.
REQ-009 SHALL provide port len  input  LEN_W  number of pattern bits per repetition.
REQ-010 SHALL provide port rep  input  REP_W  extra repetitions; pattern sent rep+1 times.
REQ-011 SHALL provide port tx_en  input  1  per-cycle bit enable (bit-rate tick).
REQ-012 SHALL provide port dout  output  1  serial bit, registered.
REQ-013 SHALL provide port dout_valid  output  1  dout carries a new bit this cycle, registered.
REQ-014 SHALL provide port done  output  1  asserted with the final bit of the last repetition.
REQ-015 SHALL provide port state  output  2  current FSM state, registered.

Function
REQ-016 SHALL implement states IDLE=2'b00, SEND=2'b01, DONE=2'b10; 2'b11 returns to IDLE next edge with all outputs 0.
REQ-017 load_ready SHALL be 1 only in IDLE; transfer occurs on an edge with load_valid && load_ready.
REQ-018 On transfer SHALL capture pattern, len (clamped to WIDTH if larger), rep; bit index = len-1; repeat counter = rep.
REQ-019 On transfer with len!=0 SHALL enter SEND; with len==0 SHALL enter DONE with done=1, dout_valid=0.
REQ-020 In SEND, on an edge with tx_en=1: dout <= pattern[index], dout_valid <= 1, index decrements.
REQ-021 In SEND, on an edge with tx_en=0: dout holds, dout_valid <= 0, index and counters unchanged.
REQ-022 When index reaches 0 with repeat counter >0: index reloads len-1, counter decrements, stays in SEND; no gap bit inserted.
REQ-023 When bit 0 of last repetition is emitted: state <= DONE and done <= 1 on the same edge as that bit's dout_valid.
REQ-024 In DONE: next edge state <= IDLE, done <= 0, dout_valid <= 0, dout <= 0, regardless of tx_en.
REQ-025 load_valid outside IDLE SHALL be ignored; a request held through DONE is accepted on the first IDLE edge.
REQ-026 With tx_en held 1, dout_valid SHALL be high for exactly len*(rep+1) consecutive cycles, starting the cycle after SEND is entered.

Reset
REQ-027 On an edge with rst=0: state=IDLE, dout=0, dout_valid=0, done=0, counters=0, load_ready=1 after the edge.
REQ-028 Reset mid-SEND SHALL abort the transfer without asserting done; no bit emitted on that edge.

Structure
REQ-029 State encodings and default parameter values SHALL live in shared package seq_fsm_pkg, common to the sequence FSM blocks.
REQ-030 Bit index and repeat down-counting SHALL be one sub-module seq_bitcnt (load, decrement-on-enable, zero flag); rest stays in seq_gen.

Verification
REQ-031 pattern=8'h07, len=3, rep=1, tx_en=1 -> dout 1,1,1,1,1,1 over 6 valid cycles, done high on 6th, IDLE next.
REQ-032 pattern=8'hA5, len=8, rep=0, tx_en toggling 1,0 -> dout 1,0,1,0,0,1,0,1 only on tx_en cycles; dout held between.
REQ-033 len=0, rep=3 -> DONE on the edge after accept, done one cycle, no dout_valid pulse.
REQ-034 len=12 with WIDTH=8, pattern=8'hFF -> clamped: exactly 8 ones, then done.
REQ-035 rst=0 on the third bit of a len=5 transfer -> next cycle IDLE, all outputs 0, done never asserted; new load accepted afterwards.
REQ-036 load_valid held high continuously, len=2 rep=0 -> back-to-back transfers with one DONE cycle and one IDLE accept cycle between.
